l1_l2_arbiter: RTL and testbench

//  Sequential arbiter sharing the single L2 request port between the L1 data and L1 instruction caches.

---
 rtl/l1_l2_arbiter_if.sv | 34 +++
 rtl/l1_l2_arbiter.sv | 83 ++++++++
 tb/tb_l1_l2_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/l1_l2_arbiter_if.sv
// l1_l2_arbiter_if: L1 data/instr request ports plus the shared L2 request port
//   d_*  : L1 data request (valid/wen/addr/wdata) and response (resp/rdata)
//   i_*  : L1 instr request (valid/addr) and response (resp/rdata)
//   l2_* : request to L2 (valid/wen/addr/wdata) and completion (ready/rdata)
//   slave  : arbiter view, master : surrounding caches / L2 view
interface l1_l2_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 128
);
  logic               d_valid_i;
  logic               d_wen_i;
  logic [ADDR_W-1:0]  d_addr_i;
  logic [BLOCK_W-1:0] d_wdata_i;
  logic               d_resp_o;
  logic [BLOCK_W-1:0] d_rdata_o;
  logic               i_valid_i;
  logic [ADDR_W-1:0]  i_addr_i;
  logic               i_resp_o;
  logic [BLOCK_W-1:0] i_rdata_o;
  logic               l2_valid_o;
  logic               l2_wen_o;
  logic [ADDR_W-1:0]  l2_addr_o;
  logic [BLOCK_W-1:0] l2_wdata_o;
  logic               l2_ready_i;
  logic [BLOCK_W-1:0] l2_rdata_i;
  modport slave (
    input  d_valid_i, d_wen_i, d_addr_i, d_wdata_i, i_valid_i, i_addr_i, l2_ready_i, l2_rdata_i,
    output d_resp_o, d_rdata_o, i_resp_o, i_rdata_o, l2_valid_o, l2_wen_o, l2_addr_o, l2_wdata_o
  );
  modport master (
    output d_valid_i, d_wen_i, d_addr_i, d_wdata_i, i_valid_i, i_addr_i, l2_ready_i, l2_rdata_i,
    input  d_resp_o, d_rdata_o, i_resp_o, i_rdata_o, l2_valid_o, l2_wen_o, l2_addr_o, l2_wdata_o
  );
endinterface

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: round-robin sharing of the single L2 request port between L1 data and L1 instr
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : L1/L2 handshake signals (slave modport)
//   grant_o       : current/last owner, 0 = data, 1 = instr
//   busy_o        : transaction in flight
//   err_o         : sticky REQ timeout flag
module l1_l2_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  l1_l2_arbiter_if.slave  bus,
  output logic            grant_o,
  output logic            busy_o,
  output logic            err_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  logic [1:0]         state;
  logic               last_i;
  logic [CW-1:0]      cnt;
  logic               wen_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic [BLOCK_W-1:0] rdata_q;
  logic               any_req;
  logic               pick_i;
  logic               d_resp;
  logic               i_resp;
  // on a tie the side that did not win last time goes next
  always_comb begin
    any_req = bus.d_valid_i | bus.i_valid_i;
    pick_i  = bus.i_valid_i & (~bus.d_valid_i | ~last_i);
    d_resp  = (state == RESP) & ~grant_o;
    i_resp  = (state == RESP) & grant_o;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      last_i  <= 1'b1;
      grant_o <= 1'b0;
      cnt     <= '0;
      err_o   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        state   <= REQ;
        grant_o <= pick_i;
        last_i  <= pick_i;
        addr_q  <= pick_i ? bus.i_addr_i : bus.d_addr_i;
        wen_q   <= ~pick_i & bus.d_wen_i;
        wdata_q <= pick_i ? '0 : bus.d_wdata_i;
      end
      if (state == REQ) begin
        cnt <= (cnt == TO) ? cnt : cnt + 1'b1;
        if (TIMEOUT != 0 && cnt == TO - 1'b1) err_o <= 1'b1;
        if (bus.l2_ready_i) begin
          rdata_q <= bus.l2_rdata_i;
          state   <= RESP;
          cnt     <= '0;
        end
      end
      if (state == RESP) state <= IDLE;
    end
  end
  assign busy_o         = state != IDLE;
  assign bus.l2_valid_o = state == REQ;
  assign bus.l2_wen_o   = wen_q;
  assign bus.l2_addr_o  = addr_q;
  assign bus.l2_wdata_o = wdata_q;
  assign bus.d_resp_o   = d_resp;
  assign bus.i_resp_o   = i_resp;
  assign bus.d_rdata_o  = d_resp ? rdata_q : '0;
  assign bus.i_rdata_o  = i_resp ? rdata_q : '0;
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter: directed and randomized checks of l1_l2_arbiter against a transaction-level model
module tb_l1_l2_arbiter;
  localparam int AW = 32;
  localparam int BW = 128;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic grant, busy, err;
  logic g;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  logic m_last_i;
  logic m_err;
  l1_l2_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus();
  l1_l2_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .grant_o(grant), .busy_o(busy), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [BW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // one complete transaction starting from an IDLE cycle with requests already driven;
  // the model decides the owner from the pending requests and the previous owner
  task automatic txn(input int delay, input logic [BW-1:0] rd, output logic gnt);
    logic win, ew;
    logic [AW-1:0] ea;
    logic [BW-1:0] ewd;
    win = (bus.d_valid_i && bus.i_valid_i) ? !m_last_i : bus.i_valid_i;
    ea  = win ? bus.i_addr_i : bus.d_addr_i;
    ew  = win ? 1'b0 : bus.d_wen_i;
    ewd = win ? '0 : bus.d_wdata_i;
    tick();
    gnt = grant;
    chk("grant", grant, win);
    chk("busy_req", busy, 1);
    for (int k = 0; k <= delay; k++) begin
      chk("l2_valid", bus.l2_valid_o, 1);
      chk("l2_addr", bus.l2_addr_o, ea);
      chk("l2_wen", bus.l2_wen_o, ew);
      chk("l2_wdata", bus.l2_wdata_o, ewd);
      chk("resp_in_req", {bus.d_resp_o, bus.i_resp_o}, 0);
      chk("err_in_req", err, m_err || k >= 8);
      bus.d_addr_i   = $urandom;
      bus.i_addr_i   = $urandom;
      bus.d_wdata_i  = rnd();
      bus.d_wen_i    = 1'($urandom);
      bus.l2_ready_i = (k == delay);
      bus.l2_rdata_i = (k == delay) ? rd : rnd();
      tick();
    end
    m_err = m_err || (delay + 1 >= 8);
    bus.l2_ready_i = 1'b0;
    bus.l2_rdata_i = rnd();
    chk("d_resp", bus.d_resp_o, !win);
    chk("i_resp", bus.i_resp_o, win);
    chk("d_rdata", bus.d_rdata_o, win ? '0 : rd);
    chk("i_rdata", bus.i_rdata_o, win ? rd : '0);
    chk("err_resp", err, m_err);
    if (win) bus.i_valid_i = 1'b0;
    else bus.d_valid_i = 1'b0;
    m_last_i = win;
    tick();
    chk("idle_resp", {bus.d_resp_o, bus.i_resp_o}, 0);
    chk("idle_rdata", {bus.d_rdata_o, bus.i_rdata_o}, 0);
    chk("idle_busy", busy, 0);
    chk("idle_l2_valid", bus.l2_valid_o, 0);
  endtask
  initial begin
    m_last_i = 1'b1;
    m_err = 1'b0;
    bus.d_valid_i = 1'b1;
    bus.i_valid_i = 1'b1;
    bus.d_wen_i = 1'b0;
    bus.d_addr_i = 32'h0000_A000;
    bus.i_addr_i = 32'h0000_B000;
    bus.d_wdata_i = '0;
    bus.l2_ready_i = 1'b0;
    bus.l2_rdata_i = '0;
    repeat (2) tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_l2_valid", bus.l2_valid_o, 0);
    chk("rst_l2_wen", bus.l2_wen_o, 0);
    chk("rst_l2_addr", bus.l2_addr_o, 0);
    chk("rst_l2_wdata", bus.l2_wdata_o, 0);
    chk("rst_resp", {bus.d_resp_o, bus.i_resp_o}, 0);
    chk("rst_rdata", {bus.d_rdata_o, bus.i_rdata_o}, 0);
    rst_n = 1'b1;
    txn(0, rnd(), g);
    chk("t1_data_first", g, 0);
    bus.i_addr_i = 32'h0000_0100;
    txn(3, {4{32'hDEAD_BEEF}}, g);
    chk("t2_instr_only", g, 1);
    for (int k = 0; k < 4; k++) begin
      bus.d_valid_i = 1'b1;
      bus.i_valid_i = 1'b1;
      txn(int'($urandom_range(0, 2)), rnd(), g);
      chk("t3_alternate", g, k % 2);
    end
    bus.i_valid_i = 1'b0;
    bus.d_valid_i = 1'b1;
    bus.d_wen_i = 1'b1;
    bus.d_addr_i = 32'h40;
    bus.d_wdata_i = 128'h1234;
    txn(2, rnd(), g);
    chk("t4_write_owner", g, 0);
    bus.d_valid_i = 1'b1;
    txn(10, rnd(), g);
    chk("t5_err_sticky", err, 1);
    bus.i_valid_i = 1'b1;
    txn(1, rnd(), g);
    bus.d_valid_i = 1'b1;
    bus.d_wen_i = 1'b0;
    tick();
    chk("t6_in_req", bus.l2_valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_l2_valid", bus.l2_valid_o, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);
    chk("t6_grant", grant, 0);
    chk("t6_resp", {bus.d_resp_o, bus.i_resp_o}, 0);
    bus.d_valid_i = 1'b0;
    m_last_i = 1'b1;
    m_err = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.l2_ready_i = 1'b1;
    bus.l2_rdata_i = rnd();
    tick();
    bus.l2_ready_i = 1'b0;
    chk("t6_ready_ignored_busy", busy, 0);
    chk("t6_ready_ignored_resp", {bus.d_resp_o, bus.i_resp_o}, 0);
    tick();
    chk("t6_still_idle", busy, 0);
    chk("t6_no_late_resp", {bus.d_resp_o, bus.i_resp_o}, 0);
    for (int n = 0; n < 24; n++) begin
      bus.d_valid_i = bus.d_valid_i | 1'($urandom);
      bus.i_valid_i = bus.i_valid_i | 1'($urandom);
      if (!bus.d_valid_i && !bus.i_valid_i) bus.d_valid_i = 1'b1;
      bus.d_wen_i = 1'($urandom);
      bus.d_addr_i = $urandom;
      bus.i_addr_i = $urandom;
      bus.d_wdata_i = rnd();
      txn(int'($urandom_range(0, 4)), rnd(), g);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
